// File: rtl/sample_frame_streamer.sv
// sample_frame_streamer: snapshots the sample history on request and
// streams it to the UART as HEADER, count, data (oldest first), checksum.
module sample_frame_streamer #(
    parameter int         NUM_BYTES = 10,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] samples_flat,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int         W     = 8 * NUM_BYTES;
    localparam logic [7:0] CNT_B = 8'(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CNT,
        DATA,
        CSUM
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [7:0]     idx;
    logic [7:0]     idx_n;
    logic [7:0]     csum;
    logic [7:0]     csum_n;
    logic [W-1:0]   snap;
    logic [W-1:0]   snap_n;
    logic [7:0]     cur;
    logic           xfer;
    logic [7:0]     tx_data_n;
    logic           tx_valid_n;
    logic           busy_n;
    logic           done_n;

    // The oldest unsent byte always sits at the top of the snapshot,
    // which is shifted left one byte per data transfer.
    assign cur  = snap[W-1 -: 8];
    assign xfer = tx_valid & tx_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; every non-idle state waits for a transfer
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = HDR;
            HDR:     if (xfer) state_n = CNT;
            CNT:     if (xfer) state_n = DATA;
            DATA:    if (xfer && idx == 8'd0) state_n = CSUM;
            CSUM:    if (xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next snapshot, index and running checksum
    always_comb begin
        idx_n  = idx;
        csum_n = csum;
        snap_n = snap;
        unique case (state)
            IDLE: if (start) snap_n = samples_flat;
            CNT: begin
                if (xfer) begin
                    csum_n = CNT_B;
                    idx_n  = CNT_B - 8'd1;
                end
            end
            DATA: begin
                if (xfer) begin
                    csum_n = csum + cur;
                    snap_n = snap << 8;
                    if (idx != 8'd0) idx_n = idx - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output values for the next cycle, decoded from the next state
    always_comb begin
        tx_valid_n = (state_n != IDLE);
        busy_n     = (state_n != IDLE);
        done_n     = (state == CSUM) && xfer;
        tx_data_n  = 8'h00;
        unique case (state_n)
            HDR:     tx_data_n = HEADER;
            CNT:     tx_data_n = CNT_B;
            DATA:    tx_data_n = snap_n[W-1 -: 8];
            CSUM:    tx_data_n = csum_n;
            default: tx_data_n = 8'h00;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            csum <= '0;
            snap <= '0;
        end else begin
            idx  <= idx_n;
            csum <= csum_n;
            snap <= snap_n;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_sample_frame_streamer.sv
// tb_sample_frame_streamer: frame-queue model checked every cycle,
// plus literal byte sequences for the directed scenarios.
module tb_sample_frame_streamer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [79:0] samples = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic        start1 = 1'b0;
    logic [7:0]  samples1 = 8'h7F;
    logic [7:0]  tx_data1;
    logic        tx_valid1;
    logic        tx_ready1 = 1'b1;
    logic        busy1;
    logic        done1;

    int errors = 0;
    int checks = 0;

    bq_t q;
    bq_t got;
    bq_t got1;
    logic m_done = 1'b0;
    int   done_cnt = 0;
    int   done1_cnt = 0;

    always #5 clk = ~clk;

    sample_frame_streamer #(.NUM_BYTES(10), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .samples_flat(samples),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    sample_frame_streamer #(.NUM_BYTES(1), .HEADER(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .samples_flat(samples1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole frame as the host should receive it
    function automatic bq_t frame_of(input logic [79:0] s);
        bq_t f;
        logic [7:0] sum;
        f.push_back(8'hA5);
        f.push_back(8'd10);
        sum = 8'd10;
        for (int i = 9; i >= 0; i--) begin
            f.push_back(s[8*i +: 8]);
            sum = sum + s[8*i +: 8];
        end
        f.push_back(sum);
        return f;
    endfunction

    // Model step and per-cycle comparison
    always @(negedge clk) begin
        logic ev;
        logic nd;
        if (rst) begin
            q.delete();
            m_done = 1'b0;
            chk("rst_valid", tx_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_data", tx_data, 0);
        end else begin
            ev = (q.size() != 0);
            chk("valid", tx_valid, ev);
            chk("busy", busy, ev);
            chk("done", done, m_done);
            if (ev) chk("data", tx_data, q[0]);
            if (done) done_cnt++;
            nd = 1'b0;
            if (ev && tx_ready) begin
                got.push_back(tx_data);
                void'(q.pop_front());
                if (q.size() == 0) nd = 1'b1;
            end else if (!ev && start) begin
                q = frame_of(samples);
            end
            m_done = nd;
        end
    end

    // Byte log for the single-sample instance
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid1 && tx_ready1) got1.push_back(tx_data1);
            if (done1) done1_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", q.size(), 0);
        tick();
        tick();
    endtask

    task automatic cmp_seq(input string nm, input bq_t exp, input bq_t act);
        chk({nm, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < act.size()) chk(nm, act[i], exp[i]);
    endtask

    task automatic fire();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bq_t seq1;
        bq_t seq2;
        bq_t seqf;
        bq_t seq4;
        logic [79:0] inc;
        seq1 = '{8'hA5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
        seq2 = '{8'hA5, 8'h0A, 8'h0A, 8'h09, 8'h08, 8'h07, 8'h06,
                 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h41};
        seqf = '{8'hA5, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        for (int i = 0; i < 10; i++) inc[8*i +: 8] = 8'(i + 1);

        repeat (3) tick();
        rst = 1'b0;
        tick();

        start1 = 1'b1;
        tick();
        start1 = 1'b0;

        // all-zero samples
        samples = '0;
        got.delete();
        fire();
        wait_idle(100);
        cmp_seq("zero_frame", seq1, got);

        // incrementing samples
        samples = inc;
        got.delete();
        fire();
        wait_idle(100);
        cmp_seq("inc_frame", seq2, got);

        // random back-pressure
        got.delete();
        fire();
        for (int n = 0; n < 400 && q.size() != 0; n++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("stall_timeout", q.size(), 0);
        tx_ready = 1'b1;
        tick();
        tick();
        cmp_seq("stall_frame", seq2, got);

        // snapshot isolation, ignored start, start on done cycle
        got.delete();
        fire();
        repeat (3) tick();
        samples = {10{8'hFF}};
        fire();
        repeat (9) tick();
        fire();
        wait_idle(100);
        seq4 = seq2;
        foreach (seqf[i]) seq4.push_back(seqf[i]);
        cmp_seq("b2b_frame", seq4, got);

        // reset in DATA at index 5
        samples = inc;
        fire();
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("async_valid", tx_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        got.delete();
        fire();
        wait_idle(100);
        cmp_seq("post_rst_frame", seq2, got);

        chk("done_count", done_cnt, 6);
        cmp_seq("one_byte_frame", '{8'hA5, 8'h01, 8'h7F, 8'h80}, got1);
        chk("done1_count", done1_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_frame_streamer.md
Name: sample_frame_streamer

Overview:
- Reader side of the 10-deep sample history register.
- On a start request it snapshots all stored 8-bit samples and streams them as one framed byte sequence to the UART transmitter.
- Uses a valid/ready byte handshake toward the transmitter.
- Sits between the sample history register (parallel outputs) and uart_tx; the frame lets the host resynchronise and integrity-check each dump.

Parameters:
- NUM_BYTES, 10, number of sample bytes per frame; range 1..255.
- HEADER, 8'hA5, sync byte sent first in every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a frame dump; sampled only in IDLE
- samples_flat  input  8*NUM_BYTES  sample history; byte i at [8i+7:8i], index 0 = newest, index NUM_BYTES-1 = oldest
- tx_data  output  8  byte offered to transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts tx_data this cycle
- busy  output  1  high from the cycle after start is accepted until the frame completes
- done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (async, any state, including mid-frame):
  - State goes to IDLE.
  - tx_valid=0, tx_data=8'h00, busy=0, done=0.
  - Snapshot, index and checksum are cleared.
  - No partial frame resumes after reset.
- Transfer rule: a byte is transferred on a rising edge where tx_valid && tx_ready.
- Handshake:
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable and tx_valid must stay high.
  - tx_valid never drops without a transfer, except on reset.
  - tx_ready while tx_valid=0 is ignored.
- States: IDLE, HDR, CNT, DATA, CSUM.
- IDLE:
  - busy=0, tx_valid=0.
  - If start=1 at the edge, copy samples_flat into an internal snapshot and go to HDR.
  - Later changes on samples_flat do not affect the frame in progress.
- HDR: tx_valid=1, tx_data=HEADER. On transfer, go to CNT.
- CNT:
  - tx_data = NUM_BYTES[7:0].
  - On transfer: checksum = NUM_BYTES, index = NUM_BYTES-1, go to DATA.
- DATA:
  - tx_data = snapshot byte[index], so bytes go oldest first (index NUM_BYTES-1 down to 0).
  - On transfer: checksum += byte (mod 256); if index==0 go to CSUM, else decrement index.
- CSUM:
  - tx_data = checksum, the 8-bit sum mod 256 of the count byte and all data bytes. HEADER is excluded.
  - On transfer, go to IDLE.
- done: asserted for exactly the first IDLE cycle after the CSUM transfer, with busy already 0.
- busy: registered; high in HDR through CSUM inclusive.
- Latency:
  - start sampled at edge k → tx_valid=1 with HEADER from edge k onward, i.e. visible in cycle k+1.
  - With tx_ready held at 1, the frame occupies NUM_BYTES+3 consecutive cycles, and done pulses in the next cycle.
- Frame length: always NUM_BYTES+3 bytes.
- start while busy: ignored, not queued.
- start in the done cycle: accepted, since the state is IDLE. The new frame begins with no gap beyond that cycle.
- tx_valid, tx_data, busy and done are all driven from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- All-zero samples, start pulse, tx_ready=1 → bytes A5 0A 00×10 0A; 13 consecutive valid cycles; done pulses once the cycle after.
- samples byte i = i+1 (newest=01, oldest=0A), tx_ready=1 → A5 0A 0A 09 08 07 06 05 04 03 02 01 41 (checksum 0x0A+55 = 0x41).
- Same stimulus with tx_ready toggling 1-0-0-1 randomly → identical byte sequence; tx_data stable and tx_valid high during every stall; busy high throughout.
- Change samples_flat to FF, and pulse start again, mid-frame → frame contents unchanged from the snapshot; no second frame starts; a start on the done cycle immediately begins a new frame with the new samples (FF ×10, checksum 0x0A+0xF6 = 0x00).
- Assert rst while in DATA at index 5 → tx_valid, busy and done drop asynchronously; after release, outputs stay idle until start; the next frame is complete and starts with A5.
- NUM_BYTES=1 build, sample 0x7F → A5 01 7F 80; done pulses once.
